cond_eval_unit: RTL



---
 rtl/cond_eval_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cond_eval_unit.sv
// Banked NZCV flag registers with masked updates, condition-code evaluation and
// saturating evaluation/match statistics for the branch/predication path.
module cond_eval_unit #(
   parameter int  NUM_BANKS = 2,
   parameter int  FORWARD   = 1,
   parameter int  COUNT_W   = 16,
   localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic               FLAG_WE,
   input  logic [3:0]         FLAG_MASK,
   input  logic [3:0]         FLAG_D,
   input  logic [BANK_W-1:0]  BANK_SEL,
   input  logic               EVAL_VALID,
   input  logic [3:0]         COND_IN,
   input  logic               CNT_CLR,
   output logic               CONDITION_MATCHED,
   output logic               RESULT_VALID,
   output logic [3:0]         FLAG_OUT,
   output logic [COUNT_W-1:0] EVAL_COUNT,
   output logic [COUNT_W-1:0] MATCH_COUNT
);

   localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

   function automatic logic cond_match(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (cond)
         4'h0:    return z;
         4'h1:    return !z;
         4'h2:    return c;
         4'h3:    return !c;
         4'h4:    return n;
         4'h5:    return !n;
         4'h6:    return v;
         4'h7:    return !v;
         4'h8:    return c && !z;
         4'h9:    return !c || z;
         4'hA:    return n == v;
         4'hB:    return n != v;
         4'hC:    return !z && (n == v);
         4'hD:    return z || (n != v);
         4'hE:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt);
      return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   endfunction

   logic [3:0]         bank_q [NUM_BANKS];
   logic [3:0]         bank_d [NUM_BANKS];
   logic               bank_ok;
   logic [3:0]         cur_flags;
   logic [3:0]         merged_flags;
   logic [3:0]         eff_flags;
   logic               hit;
   logic               matched_q, matched_d;
   logic               valid_q, valid_d;
   logic [3:0]         flag_out_q, flag_out_d;
   logic [COUNT_W-1:0] eval_cnt_q, eval_cnt_d;
   logic [COUNT_W-1:0] match_cnt_q, match_cnt_d;

   always_comb begin
      bank_ok      = int'(BANK_SEL) < NUM_BANKS;
      bank_d       = bank_q;
      cur_flags    = 4'b0000;
      merged_flags = 4'b0000;
      if (bank_ok) begin
         cur_flags    = bank_q[BANK_SEL];
         merged_flags = (cur_flags & ~FLAG_MASK) | (FLAG_D & FLAG_MASK);
      end
      if (FLAG_WE && bank_ok) begin
         bank_d[BANK_SEL] = merged_flags;
      end

      // Out-of-range selects leave both candidates at 0000, so no extra guard here.
      eff_flags = ((FORWARD != 0) && FLAG_WE) ? merged_flags : cur_flags;
      hit       = cond_match(COND_IN, eff_flags);

      valid_d    = EVAL_VALID;
      matched_d  = EVAL_VALID ? hit : matched_q;
      flag_out_d = bank_ok ? bank_d[BANK_SEL] : 4'b0000;

      eval_cnt_d  = eval_cnt_q;
      match_cnt_d = match_cnt_q;
      if (CNT_CLR) begin
         eval_cnt_d  = '0;
         match_cnt_d = '0;
      end else if (EVAL_VALID) begin
         eval_cnt_d = sat_inc(eval_cnt_q);
         if (hit) begin
            match_cnt_d = sat_inc(match_cnt_q);
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            bank_q[i] <= 4'b0000;
         end
         matched_q   <= 1'b0;
         valid_q     <= 1'b0;
         flag_out_q  <= 4'b0000;
         eval_cnt_q  <= '0;
         match_cnt_q <= '0;
      end else begin
         bank_q      <= bank_d;
         matched_q   <= matched_d;
         valid_q     <= valid_d;
         flag_out_q  <= flag_out_d;
         eval_cnt_q  <= eval_cnt_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   assign CONDITION_MATCHED = matched_q;
   assign RESULT_VALID      = valid_q;
   assign FLAG_OUT          = flag_out_q;
   assign EVAL_COUNT        = eval_cnt_q;
   assign MATCH_COUNT       = match_cnt_q;

endmodule
